// File: rtl/select_sharing_arbiter_pkg.sv
// Shared helpers for the select sharing arbiter.
package select_sharing_arbiter_pkg;

  // Round-robin index: (base + offset) mod n, for base < n and offset < n.
  function automatic int rr_index(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/select_sharing_arbiter_output_buffer.sv
// Per-requester result FIFO. It holds up to DEPTH results, and the head is
// visible combinationally. A push together with a pop on a full buffer is
// accepted and leaves the occupancy unchanged.
module sharing_output_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (do_pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)
        count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push)
        count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/select_sharing_arbiter.sv
// One registered select unit (cond ? true : false) shared round-robin among
// NUM_SHARED requesters. Credits reserve an output buffer slot before a grant,
// so the pipeline never stalls and a slow consumer only blocks itself.
import select_sharing_arbiter_pkg::*;

module select_sharing_arbiter #(
  parameter int NUM_SHARED = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int CREDITS    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SHARED-1:0]            ins_condition,
  input  logic [NUM_SHARED*DATA_WIDTH-1:0] ins_trueValue,
  input  logic [NUM_SHARED*DATA_WIDTH-1:0] ins_falseValue,
  input  logic [NUM_SHARED-1:0]            ins_valid,
  output logic [NUM_SHARED-1:0]            ins_ready,
  output logic [NUM_SHARED*DATA_WIDTH-1:0] outs,
  output logic [NUM_SHARED-1:0]            outs_valid,
  input  logic [NUM_SHARED-1:0]            outs_ready
);

  localparam int TAG_W  = $clog2(NUM_SHARED);
  localparam int CRED_W = $clog2(CREDITS + 1);

  logic [TAG_W-1:0]                        ptr_reg;
  logic [NUM_SHARED-1:0][CRED_W-1:0]       credit_reg;
  logic [NUM_SHARED-1:0]                   eligible;
  logic [NUM_SHARED-1:0]                   grant;
  logic                                    grant_any;
  logic [TAG_W-1:0]                        grant_idx;
  int                                      arb_idx;
  logic [DATA_WIDTH-1:0]                   sel_result;

  logic                                    pipe_valid_reg [LATENCY];
  logic [TAG_W-1:0]                        pipe_tag_reg   [LATENCY];
  logic [DATA_WIDTH-1:0]                   pipe_data_reg  [LATENCY];

  logic [NUM_SHARED-1:0]                   push_vec;
  logic [NUM_SHARED-1:0]                   pop_vec;
  logic [NUM_SHARED-1:0]                   empty_vec;
  logic [NUM_SHARED-1:0]                   full_vec;
  logic [NUM_SHARED-1:0][DATA_WIDTH-1:0]   head_vec;

  // A non-zero credit already implies a free buffer slot; the full term is a
  // redundant guard against ever pushing into a full buffer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHARED; gi++) begin : g_elig
      assign eligible[gi] = ins_valid[gi] && (credit_reg[gi] != '0) && !full_vec[gi];
    end
  endgenerate

  // Round-robin search for the first eligible requester starting at ptr.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_SHARED; k++) begin
      arb_idx = rr_index(int'(ptr_reg), k, NUM_SHARED);
      if (!grant_any && eligible[arb_idx[TAG_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = arb_idx[TAG_W-1:0];
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign ins_ready = rst ? '0 : grant;

  assign sel_result = ins_condition[grant_idx]
                    ? ins_trueValue[grant_idx*DATA_WIDTH +: DATA_WIDTH]
                    : ins_falseValue[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin pointer moves just past the granted requester.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_reg <= '0;
    else if (grant_any)
      ptr_reg <= (grant_idx == TAG_W'(NUM_SHARED - 1)) ? '0 : grant_idx + TAG_W'(1);
  end

  // Valid bits of the result pipeline; shifts every cycle, never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) pipe_valid_reg[s] <= 1'b0;
    end else begin
      pipe_valid_reg[0] <= grant_any;
      for (int s = 1; s < LATENCY; s++) pipe_valid_reg[s] <= pipe_valid_reg[s-1];
    end
  end

  // Tag and result payload of the pipeline; qualified by the valid bits.
  always_ff @(posedge clk) begin
    pipe_tag_reg[0]  <= grant_idx;
    pipe_data_reg[0] <= sel_result;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_tag_reg[s]  <= pipe_tag_reg[s-1];
      pipe_data_reg[s] <= pipe_data_reg[s-1];
    end
  end

  // Credits: spent on grant, returned on pop, unchanged when both coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SHARED; i++) credit_reg[i] <= CRED_W'(CREDITS);
    end else begin
      for (int i = 0; i < NUM_SHARED; i++) begin
        if (grant[i] && !pop_vec[i])
          credit_reg[i] <= credit_reg[i] - CRED_W'(1);
        else if (pop_vec[i] && !grant[i])
          credit_reg[i] <= credit_reg[i] + CRED_W'(1);
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_SHARED; gi++) begin : g_req
      assign push_vec[gi] = pipe_valid_reg[LATENCY-1] && (pipe_tag_reg[LATENCY-1] == TAG_W'(gi));
      assign pop_vec[gi]  = !empty_vec[gi] && outs_ready[gi];
      assign outs_valid[gi] = !rst && !empty_vec[gi];
      assign outs[gi*DATA_WIDTH +: DATA_WIDTH] = (rst || empty_vec[gi]) ? '0 : head_vec[gi];

      sharing_output_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CREDITS)
      ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_vec[gi]),
        .push_data (pipe_data_reg[LATENCY-1]),
        .pop       (pop_vec[gi]),
        .empty     (empty_vec[gi]),
        .full      (full_vec[gi]),
        .head      (head_vec[gi])
      );
    end
  endgenerate

endmodule
